ffsr_pulse_ctrl: RTL and testbench
==================================

Name: ffsr_pulse_ctrl

Overview:
- Controller and arbiter that shares one ffsr_pulse shift register between NUM_REQ requesters.
- Owns the register's load sequence: drives its rst/init pins, serialises inc/dec requests round-robin, and keeps a shadow level so the register never over- or under-flows.
- Sits between spike-generating neurons and the shared pulse encoder.

Parameters:
- INPUT_SIZE, 16, width of the controlled ffsr_pulse (init/out width; max level).
- NUM_REQ, 4, number of requesters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- cfg_load  in  1  request to (re)load the register with cfg_init.
- cfg_init  in  INPUT_SIZE  value to load.
- req_inc  in  NUM_REQ  per-requester increment request, held until granted.
- req_dec  in  NUM_REQ  per-requester decrement request, held until granted.
- gnt  out  NUM_REQ  combinational grant; request accepted at the edge where gnt[i]=1.
- ffsr_rst  out  1  to ffsr_pulse rst; loads ffsr_init when high.
- ffsr_init  out  INPUT_SIZE  to ffsr_pulse init.
- ffsr_inc  out  1  registered, to ffsr_pulse inc.
- ffsr_dec  out  1  registered, to ffsr_pulse dec.
- level  out  $clog2(INPUT_SIZE+1)  shadow count of ones in the register.
- full  out  1  level==INPUT_SIZE.
- empty  out  1  level==0.
- busy  out  1  state != RUN.

Behaviour:
- Reset (rst=0 at edge):
  - state=IDLE, level=0, rr_ptr=0.
  - ffsr_rst=1, ffsr_init=0, ffsr_inc=ffsr_dec=0.
  - gnt=0, busy=1.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: ffsr_rst=1; gnt=0. cfg_load=1 -> LOAD; latch ffsr_init<=cfg_init and level<=popcount(cfg_init).
  - LOAD: exactly one cycle with ffsr_rst=1, ffsr_init holding the latched value; next state is RUN.
  - RUN: ffsr_rst=0; arbitration active. cfg_load=1 -> LOAD with the same latching; no grant is issued in that cycle.
- Eligibility, requester i in RUN:
  - req_inc[i]&~req_dec[i] is eligible iff level<INPUT_SIZE.
  - req_dec[i]&~req_inc[i] is eligible iff level>0.
  - Both set or neither set: not eligible, never granted.
  - An ineligible request stays pending; it is not dropped.
- Arbitration:
  - Round-robin, one grant per cycle. Search starts at rr_ptr and wraps modulo NUM_REQ.
  - On a grant to i, rr_ptr<=(i+1)%NUM_REQ. With no grant, rr_ptr holds.
  - gnt is one-hot or zero.
- Datapath update at the granting edge:
  - level+=1 for inc, -=1 for dec.
  - ffsr_inc/ffsr_dec register the granted op, so the pulse reaches the register 1 cycle after the grant and lasts 1 cycle.
  - Without a grant, both are 0 next cycle.
- full/empty are combinational from level. level never leaves [0, INPUT_SIZE].
- Reset mid-operation: any pending ffsr_inc/dec is squashed next cycle and all state returns to reset values.

Optional Feature:
- Macro: FFSR_CTRL_MERGE_EN.
- Defined: in RUN, if at least one eligible inc requester and one eligible dec requester exist, grant both in the same cycle. Each is the first of its type in round-robin order from rr_ptr.
  - level is unchanged; ffsr_inc=ffsr_dec=0 next cycle.
  - rr_ptr<=(higher-indexed of the two winners + 1)%NUM_REQ.
  - gnt may have two bits set.
  - Eligibility is checked against the pre-merge level, so a merge is legal at full or empty when the respective op is eligible.
- Undefined: at most one grant per cycle, as in Behaviour.

Test Plan:
- Reset then cfg_load with cfg_init=16'h00FF -> ffsr_rst high through the LOAD cycle, ffsr_init=16'h00FF, level=8, busy falls on entry to RUN.
- In RUN with level=8, req_inc=4'b1111 held continuously -> grants in order 0,1,2,3,0,... one per cycle; ffsr_inc high 1 cycle after each grant; level reaches 16 after 8 grants, then full=1 and gnt=0.
- At level=16, req_inc[1]=1 and req_dec[2]=1 -> only requester 2 granted; level=15; requester 1 granted the following cycle; level=16.
- At level=0, req_dec=4'b0001 -> no grant, empty=1. Then req_inc[0]=req_dec[0]=1 -> still no grant.
- cfg_load asserted in RUN while req_inc[3]=1 -> no grant that cycle; LOAD cycle follows; requester 3 granted on the first RUN cycle.
- With FFSR_CTRL_MERGE_EN, level=5, req_inc[0]=1, req_dec[2]=1 -> gnt=4'b0101, level stays 5, ffsr_inc=ffsr_dec=0, rr_ptr=3. Without the macro -> gnt=4'b0001, level=6.

Source files
------------

// File: rtl/ffsr_pulse_ctrl_if.sv
// ----------------------------------------------------------------------------
// ffsr_pulse_ctrl_if
// Bundles the configuration and requester handshake of ffsr_pulse_ctrl.
//   cfg_load / cfg_init : (re)load request and the value to load
//   req_inc / req_dec   : per-requester requests, held until granted
//   gnt                 : combinational grant, the request is taken at the edge
//                         where its gnt bit is high
// Modports: master = requesters/configuration side, slave = controller side.
// ----------------------------------------------------------------------------
interface ffsr_pulse_ctrl_if #(
  parameter int INPUT_SIZE = 16,
  parameter int NUM_REQ    = 4
);
  logic                  cfg_load;
  logic [INPUT_SIZE-1:0] cfg_init;
  logic [NUM_REQ-1:0]    req_inc;
  logic [NUM_REQ-1:0]    req_dec;
  logic [NUM_REQ-1:0]    gnt;

  modport master (output cfg_load, cfg_init, req_inc, req_dec, input gnt);
  modport slave  (input cfg_load, cfg_init, req_inc, req_dec, output gnt);
endinterface

// File: rtl/ffsr_pulse_ctrl.sv
// ----------------------------------------------------------------------------
// ffsr_pulse_ctrl
// Shares one ffsr_pulse shift register between NUM_REQ requesters. Drives the
// register's rst/init pins for the load sequence, serialises inc/dec requests
// round-robin and keeps a shadow level so the register cannot over/underflow.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-low reset
//   bus          ffsr_pulse_ctrl_if.slave (cfg_load, cfg_init, req_inc,
//                req_dec in; gnt out)
//   ffsr_rst_o   to ffsr_pulse rst (loads ffsr_init while high)
//   ffsr_init_o  to ffsr_pulse init
//   ffsr_inc_o   registered increment pulse
//   ffsr_dec_o   registered decrement pulse
//   level_o      shadow count of ones in the register
//   full_o       level == INPUT_SIZE
//   empty_o      level == 0
//   busy_o       controller not in RUN
//
// Optional build macro FFSR_CTRL_MERGE_EN: when an eligible inc and an
// eligible dec requester exist in the same RUN cycle, both are granted and
// cancel out (no pulse, level unchanged).
//
// state | meaning
// IDLE  | after reset, register held in rst, waiting for cfg_load
// LOAD  | one cycle of ffsr_rst with the latched init value
// RUN   | register live, round-robin arbitration of inc/dec requests
// ----------------------------------------------------------------------------
module ffsr_pulse_ctrl #(
  parameter int INPUT_SIZE = 16,
  parameter int NUM_REQ    = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  ffsr_pulse_ctrl_if.slave                 bus,
  output logic                             ffsr_rst_o,
  output logic [INPUT_SIZE-1:0]            ffsr_init_o,
  output logic                             ffsr_inc_o,
  output logic                             ffsr_dec_o,
  output logic [$clog2(INPUT_SIZE+1)-1:0]  level_o,
  output logic                             full_o,
  output logic                             empty_o,
  output logic                             busy_o
);

  localparam int LW = $clog2(INPUT_SIZE + 1);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [LW-1:0] MAX_LVL = LW'(INPUT_SIZE);
  localparam logic [LW-1:0] ONE     = LW'(1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t                state_q, state_d;
  logic [LW-1:0]         level_q, level_d;
  logic [PW-1:0]         rr_q, rr_d;
  logic [INPUT_SIZE-1:0] init_q, init_d;
  logic                  inc_q, inc_d;
  logic                  dec_q, dec_d;
  logic [NUM_REQ-1:0]    gnt_d;

  logic [NUM_REQ-1:0]    inc_ok, dec_ok;
  logic                  any_found;
  logic [PW-1:0]         any_idx;
`ifdef FFSR_CTRL_MERGE_EN
  logic                  inc_found, dec_found;
  logic [PW-1:0]         inc_idx, dec_idx;
`endif

  function automatic logic [LW-1:0] popcount(input logic [INPUT_SIZE-1:0] v);
    logic [LW-1:0] c;
    c = '0;
    for (int i = 0; i < INPUT_SIZE; i++) c = c + {{(LW-1){1'b0}}, v[i]};
    return c;
  endfunction

  function automatic logic [PW-1:0] ptr_after(input logic [PW-1:0] idx);
    return PW'((int'(idx) + 1) % NUM_REQ);
  endfunction

  // A requester asserting both inc and dec is never eligible.
  always_comb begin
    inc_ok = bus.req_inc & ~bus.req_dec & {NUM_REQ{level_q < MAX_LVL}};
    dec_ok = bus.req_dec & ~bus.req_inc & {NUM_REQ{level_q != '0}};
  end

  // Round-robin search starting at rr_q.
  always_comb begin
    any_found = 1'b0;
    any_idx   = '0;
`ifdef FFSR_CTRL_MERGE_EN
    inc_found = 1'b0;
    inc_idx   = '0;
    dec_found = 1'b0;
    dec_idx   = '0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      logic [PW-1:0] idx;
      idx = PW'((int'(rr_q) + k) % NUM_REQ);
      if (!any_found && (inc_ok[idx] || dec_ok[idx])) begin
        any_found = 1'b1;
        any_idx   = idx;
      end
`ifdef FFSR_CTRL_MERGE_EN
      if (!inc_found && inc_ok[idx]) begin
        inc_found = 1'b1;
        inc_idx   = idx;
      end
      if (!dec_found && dec_ok[idx]) begin
        dec_found = 1'b1;
        dec_idx   = idx;
      end
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    rr_d    = rr_q;
    init_d  = init_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    gnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (bus.cfg_load) begin
          state_d = LOAD;
          init_d  = bus.cfg_init;
          level_d = popcount(bus.cfg_init);
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        // A reload takes priority over arbitration in the same cycle.
        if (bus.cfg_load) begin
          state_d = LOAD;
          init_d  = bus.cfg_init;
          level_d = popcount(bus.cfg_init);
        end else begin
`ifdef FFSR_CTRL_MERGE_EN
          if (inc_found && dec_found) begin
            // Paired inc/dec cancel: no pulse, level unchanged.
            gnt_d[inc_idx] = 1'b1;
            gnt_d[dec_idx] = 1'b1;
            rr_d = ptr_after((inc_idx > dec_idx) ? inc_idx : dec_idx);
          end else
`endif
          if (any_found) begin
            gnt_d[any_idx] = 1'b1;
            rr_d = ptr_after(any_idx);
            if (inc_ok[any_idx]) begin
              inc_d   = 1'b1;
              level_d = level_q + ONE;
            end else begin
              dec_d   = 1'b1;
              level_d = level_q - ONE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      level_q <= '0;
      rr_q    <= '0;
      init_q  <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      rr_q    <= rr_d;
      init_q  <= init_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end
  end

  assign bus.gnt     = gnt_d;
  assign ffsr_rst_o  = (state_q != RUN);
  assign ffsr_init_o = init_q;
  assign ffsr_inc_o  = inc_q;
  assign ffsr_dec_o  = dec_q;
  assign level_o     = level_q;
  assign full_o      = (level_q == MAX_LVL);
  assign empty_o     = (level_q == '0);
  assign busy_o      = (state_q != RUN);

endmodule

// File: tb/tb_ffsr_pulse_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ffsr_pulse_ctrl
// Directed bench for ffsr_pulse_ctrl (INPUT_SIZE=16, NUM_REQ=4). Expected
// values are hand-computed constants; the merge case follows the build macro.
// ----------------------------------------------------------------------------
module tb_ffsr_pulse_ctrl;

  localparam int INPUT_SIZE = 16;
  localparam int NUM_REQ    = 4;

  logic        clk_i;
  logic        rst_i;
  logic        ffsr_rst_o;
  logic [15:0] ffsr_init_o;
  logic        ffsr_inc_o;
  logic        ffsr_dec_o;
  logic [4:0]  level_o;
  logic        full_o;
  logic        empty_o;
  logic        busy_o;

  int n_chk  = 0;
  int n_pass = 0;

  ffsr_pulse_ctrl_if #(.INPUT_SIZE(INPUT_SIZE), .NUM_REQ(NUM_REQ)) bus ();

  ffsr_pulse_ctrl #(.INPUT_SIZE(INPUT_SIZE), .NUM_REQ(NUM_REQ)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .bus         (bus),
    .ffsr_rst_o  (ffsr_rst_o),
    .ffsr_init_o (ffsr_init_o),
    .ffsr_inc_o  (ffsr_inc_o),
    .ffsr_dec_o  (ffsr_dec_o),
    .level_o     (level_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Returns 1 time unit after the rising edge so registered outputs are stable.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_i        = 1'b0;
    bus.cfg_load = 1'b0;
    bus.cfg_init = '0;
    bus.req_inc  = '0;
    bus.req_dec  = '0;
    tick();
    tick();

    // Reset state
    chk("rst_ffsr_rst", 32'(ffsr_rst_o), 1);
    chk("rst_init",     32'(ffsr_init_o), 0);
    chk("rst_inc",      32'(ffsr_inc_o), 0);
    chk("rst_dec",      32'(ffsr_dec_o), 0);
    chk("rst_level",    32'(level_o), 0);
    chk("rst_empty",    32'(empty_o), 1);
    chk("rst_busy",     32'(busy_o), 1);
    bus.req_inc = 4'b1111;
    #1;
    chk("rst_idle_gnt", 32'(bus.gnt), 0);
    bus.req_inc = '0;
    rst_i = 1'b1;
    tick();

    // Load 0x00FF
    bus.cfg_init = 16'h00FF;
    bus.cfg_load = 1'b1;
    #1;
    chk("idle_gnt", 32'(bus.gnt), 0);
    tick();
    bus.cfg_load = 1'b0;
    #1;
    chk("load_ffsr_rst", 32'(ffsr_rst_o), 1);
    chk("load_init",     32'(ffsr_init_o), 32'h00FF);
    chk("load_level",    32'(level_o), 8);
    chk("load_busy",     32'(busy_o), 1);
    tick();
    chk("run_busy",     32'(busy_o), 0);
    chk("run_ffsr_rst", 32'(ffsr_rst_o), 0);

    // Fill to full with all requesters incrementing
    bus.req_inc = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fill_gnt", 32'(bus.gnt), 32'(1 << (i % 4)));
      tick();
      chk("fill_level", 32'(level_o), 32'(9 + i));
      chk("fill_pulse", 32'(ffsr_inc_o), 1);
    end
    chk("full_flag", 32'(full_o), 1);
    chk("full_gnt",  32'(bus.gnt), 0);
    tick();
    chk("full_pulse_off", 32'(ffsr_inc_o), 0);
    chk("full_level",     32'(level_o), 16);

    // At full: inc blocked, dec granted, then inc after dec
    bus.req_inc = 4'b0010;
    bus.req_dec = 4'b0100;
    #1;
    chk("full_dec_gnt", 32'(bus.gnt), 32'b0100);
    tick();
    chk("full_dec_level", 32'(level_o), 15);
    chk("full_dec_pulse", 32'(ffsr_dec_o), 1);
    bus.req_dec = '0;
    #1;
    chk("refill_gnt", 32'(bus.gnt), 32'b0010);
    tick();
    chk("refill_level", 32'(level_o), 16);
    chk("refill_inc",   32'(ffsr_inc_o), 1);
    chk("refill_dec",   32'(ffsr_dec_o), 0);
    bus.req_inc = '0;

    // Drain to empty; pointer is at 2
    bus.req_dec = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("drain_gnt", 32'(bus.gnt), 32'(1 << ((2 + i) % 4)));
      tick();
    end
    chk("drain_level", 32'(level_o), 0);
    chk("drain_empty", 32'(empty_o), 1);
    bus.req_dec = 4'b0001;
    #1;
    chk("empty_gnt", 32'(bus.gnt), 0);
    tick();
    chk("empty_level", 32'(level_o), 0);
    chk("empty_dec_off", 32'(ffsr_dec_o), 0);
    bus.req_inc = 4'b0001;
    #1;
    chk("both_gnt", 32'(bus.gnt), 0);
    tick();
    chk("both_level", 32'(level_o), 0);
    bus.req_inc = '0;
    bus.req_dec = '0;

    // Reload in RUN while requester 3 is waiting; pointer is at 2
    bus.cfg_init = 16'h001F;
    bus.cfg_load = 1'b1;
    bus.req_inc  = 4'b1000;
    #1;
    chk("reload_gnt", 32'(bus.gnt), 0);
    tick();
    bus.cfg_load = 1'b0;
    #1;
    chk("reload_busy",  32'(busy_o), 1);
    chk("reload_rst",   32'(ffsr_rst_o), 1);
    chk("reload_level", 32'(level_o), 5);
    chk("reload_inc",   32'(ffsr_inc_o), 0);
    chk("reload_load_gnt", 32'(bus.gnt), 0);
    tick();
    chk("reload_run_gnt", 32'(bus.gnt), 32'b1000);
    tick();
    chk("reload_req3_level", 32'(level_o), 6);
    chk("reload_req3_inc",   32'(ffsr_inc_o), 1);
    bus.req_inc = '0;

    // Reload to level 5 again; pointer is at 0
    bus.cfg_load = 1'b1;
    tick();
    bus.cfg_load = 1'b0;
    tick();
    chk("merge_pre_level", 32'(level_o), 5);
    bus.req_inc = 4'b0001;
    bus.req_dec = 4'b0100;
    #1;
`ifdef FFSR_CTRL_MERGE_EN
    chk("merge_gnt", 32'(bus.gnt), 32'b0101);
    tick();
    chk("merge_level", 32'(level_o), 5);
    chk("merge_inc",   32'(ffsr_inc_o), 0);
    chk("merge_dec",   32'(ffsr_dec_o), 0);
`else
    chk("merge_gnt", 32'(bus.gnt), 32'b0001);
    tick();
    chk("merge_level", 32'(level_o), 6);
    chk("merge_inc",   32'(ffsr_inc_o), 1);
    chk("merge_dec",   32'(ffsr_dec_o), 0);
`endif
    // Pointer is 3 (merge) or 1 (single); either way requester 3 wins over 0
    bus.req_dec = '0;
    bus.req_inc = 4'b1001;
    #1;
    chk("post_merge_gnt", 32'(bus.gnt), 32'b1000);
    tick();
    bus.req_inc = 4'b0001;
    #1;
    chk("pre_rst_gnt", 32'(bus.gnt), 32'b0001);
    tick();
    chk("pre_rst_inc", 32'(ffsr_inc_o), 1);

    // Reset mid-operation squashes the pending pulse
    rst_i = 1'b0;
    tick();
    chk("midrst_inc",   32'(ffsr_inc_o), 0);
    chk("midrst_level", 32'(level_o), 0);
    chk("midrst_busy",  32'(busy_o), 1);
    chk("midrst_rst",   32'(ffsr_rst_o), 1);
    chk("midrst_init",  32'(ffsr_init_o), 0);
    chk("midrst_gnt",   32'(bus.gnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
